// File: rtl/xnor_rca16_aor_enc32.sv
// Key-locked 16-bit ripple-carry adder built from XNOR full adders, 17-bit sum registered (1-cycle latency).
// Define XRCA_KEY_LOCK_EN to insert the 32 key gates; without it keyinput is ignored and the sum is plain.
module xnor_rca16_aor_enc32 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] add1_i,
   input  logic [15:0] add2_i,
   input  logic [31:0] keyinput,
   output logic [16:0] result_o
);

   localparam logic [31:0] KEY = 32'h2E770869;

   logic [15:0] sum_l;
   logic [16:0] result_d;
   logic [16:0] result_q;

`ifndef XRCA_KEY_LOCK_EN
   logic unused_key;
   assign unused_key = ^keyinput;
`endif

   always_comb begin
      logic cc;
      logic p;
      logic s;
      logic carry;
      cc    = 1'b0;
      p     = 1'b0;
      s     = 1'b0;
      carry = 1'b0;
      sum_l = '0;
      for (int j = 0; j < 16; j++) begin
         p     = ~(add1_i[j] ^ add2_i[j]);
         s     = ~(p ^ cc);
         carry = (add1_i[j] & add2_i[j]) | (cc & ~p);
`ifdef XRCA_KEY_LOCK_EN
         // A 1 in KEY selects an XNOR key gate, a 0 an XOR, so both transparent under the right key.
         sum_l[j] = KEY[2*j]   ? ~(s ^ keyinput[2*j])       : (s ^ keyinput[2*j]);
         cc       = KEY[2*j+1] ? ~(carry ^ keyinput[2*j+1]) : (carry ^ keyinput[2*j+1]);
`else
         sum_l[j] = s;
         cc       = carry;
`endif
      end
      result_d = {cc, sum_l};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign result_o = result_q;

endmodule

// File: tb/tb_xnor_rca16_aor_enc32.sv
// Bench for xnor_rca16_aor_enc32: directed spec vectors plus randomized keys/operands against a bit-serial arithmetic model.
`timescale 1ns/1ps
module tb_xnor_rca16_aor_enc32;

   localparam logic [31:0] KEY = 32'h2E770869;
`ifdef XRCA_KEY_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [15:0] add1_i = '0;
   logic [15:0] add2_i = '0;
   logic [31:0] keyinput = '0;
   logic [16:0] result_o;

   int n_checks = 0;
   int n_fail   = 0;

   xnor_rca16_aor_enc32 dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .add1_i   (add1_i),
      .add2_i   (add2_i),
      .keyinput (keyinput),
      .result_o (result_o)
   );

   always #5 clk_i = ~clk_i;

   // Per-bit column addition; a wrong key bit flips that bit's sum or its carry-out.
   function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [31:0] k);
      logic [31:0] flip;
      logic [16:0] r;
      int c;
      int t;
      flip = LOCK ? (k ^ KEY) : 32'h0;
      c = 0;
      r = '0;
      for (int j = 0; j < 16; j++) begin
         t    = int'(a[j]) + int'(b[j]) + c;
         r[j] = (t % 2 == 1) ^ flip[2*j];
         c    = ((t / 2) == 1) ^ flip[2*j+1] ? 1 : 0;
      end
      r[16] = (c == 1);
      return r;
   endfunction

   task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] k);
      @(negedge clk_i);
      rst_i    = r;
      add1_i   = a;
      add2_i   = b;
      keyinput = k;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 16'($urandom), 16'($urandom), $urandom);
         n_checks++;
         if (result_o !== 17'h00000) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %h expected 00000", i, result_o);
         end
      end
      step(1'b0, 16'h29AF, 16'h7A1B, KEY);
      n_checks++;
      if (result_o !== 17'h0A3CA) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected 0A3CA", result_o);
      end
   endtask

   task automatic test_correct_sweep();
      logic [15:0] ta [6];
      logic [15:0] tb [6];
      logic [16:0] te [6];
      ta = '{16'h8943, 16'h5555, 16'h8051, 16'hFADC, 16'h1111, 16'h0000};
      tb = '{16'hFFFF, 16'hAAAA, 16'h8086, 16'h00DC, 16'hEEAA, 16'h0001};
      te = '{17'h18942, 17'h0FFFF, 17'h100D7, 17'h0FBB8, 17'h0FFBB, 17'h00001};
      for (int i = 0; i < 6; i++) begin
         step(1'b0, ta[i], tb[i], KEY);
         n_checks++;
         if (result_o !== te[i]) begin
            n_fail++;
            $display("FAIL sweep %h+%h: got %h expected %h", ta[i], tb[i], result_o, te[i]);
         end
      end
   endtask

   task automatic test_wrong_key();
      logic [15:0] wa [4];
      logic [15:0] wb [4];
      logic [31:0] wk [4];
      logic [16:0] we [4];
      logic [16:0] exp_v;
      wa = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
      wb = '{16'h0000, 16'h0001, 16'h0000, 16'h0000};
      wk = '{KEY ^ 32'h1, KEY ^ 32'h1, KEY ^ 32'h2, KEY ^ 32'h80000000};
      we = '{17'h00001, 17'h10001, 17'h00002, 17'h10000};
      for (int i = 0; i < 4; i++) begin
         exp_v = LOCK ? we[i] : ({1'b0, wa[i]} + {1'b0, wb[i]});
         step(1'b0, wa[i], wb[i], wk[i]);
         n_checks++;
         if (result_o !== exp_v) begin
            n_fail++;
            $display("FAIL wrong_key[%0d] key=%h: got %h expected %h", i, wk[i], result_o, exp_v);
         end
      end
   endtask

   task automatic test_key_zero();
      logic [16:0] exp_v;
      exp_v = LOCK ? model(16'h29AF, 16'h7A1B, 32'h0) : 17'h0A3CA;
      step(1'b0, 16'h29AF, 16'h7A1B, 32'h0);
      n_checks++;
      if (result_o !== exp_v) begin
         n_fail++;
         $display("FAIL key_zero: got %h expected %h", result_o, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] prev;
      logic [16:0] exp_v;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] k;
      logic        r;
      prev = result_o;
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         k = (i % 3 == 0) ? (KEY ^ (32'h1 << $urandom_range(31, 0))) : KEY;
         r = (i == 20);
         @(negedge clk_i);
         rst_i    = r;
         add1_i   = a;
         add2_i   = b;
         keyinput = k;
         #1;
         n_checks++;
         if (result_o !== prev) begin
            n_fail++;
            $display("FAIL b2b_hold[%0d]: got %h expected %h", i, result_o, prev);
         end
         exp_v = r ? 17'h00000 : model(a, b, k);
         @(posedge clk_i);
         #1;
         n_checks++;
         if (result_o !== exp_v) begin
            n_fail++;
            $display("FAIL b2b[%0d] %h+%h key=%h rst=%0b: got %h expected %h",
                     i, a, b, k, r, result_o, exp_v);
         end
         prev = exp_v;
      end
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] k;
      logic [16:0] exp_v;
      for (int i = 0; i < 300; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         case (i % 3)
            0:       k = KEY;
            1:       k = KEY ^ (32'h1 << $urandom_range(31, 0));
            default: k = $urandom;
         endcase
         exp_v = model(a, b, k);
         step(1'b0, a, b, k);
         n_checks++;
         if (result_o !== exp_v) begin
            n_fail++;
            $display("FAIL random[%0d] %h+%h key=%h: got %h expected %h",
                     i, a, b, k, result_o, exp_v);
         end
         if (k == KEY) begin
            n_checks++;
            if (result_o !== ({1'b0, a} + {1'b0, b})) begin
               n_fail++;
               $display("FAIL random_sum[%0d] %h+%h: got %h expected %h",
                        i, a, b, result_o, {1'b0, a} + {1'b0, b});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_correct_sweep();
      test_wrong_key();
      test_key_zero();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
